fp_sub_seq: RTL and testbench

- Iterative IEEE-754 single-precision subtractor computing Diff = A - B over multiple cycles.
- It is the counterpart of the combinational floating-point adder in the arithmetic datapath. It shares that block's operand format and its overflow-flag (Cout) semantics.
- A start/done handshake lets a controller issue one operation at a time.
- Alignment and normalization shift by one bit per cycle, which trades latency for area.

---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_unpack.sv | 47 ++++
 rtl/fp_sub_seq.sv | 148 ++++++++++++++
 tb/tb_fp_sub_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the fp add/sub datapath.
package fp_pkg;
  localparam int SIGN  = 31;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, DONE} state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;
endpackage

// File: rtl/fp_unpack.sv
// Field split, zero/special detect and magnitude-ordered swap of two operands.
// op0 always carries the larger magnitude; b's sign is inverted (subtract).
module fp_unpack
  import fp_pkg::*;
#(
  parameter int GUARD_BITS = 2,
  parameter int MAX_ALIGN  = 26,
  localparam int MW = 1 + MAN_W + GUARD_BITS,
  localparam int AW = $clog2(MAX_ALIGN + 1)
) (
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             special,
  output logic             s0,
  output logic             s1,
  output logic [EXP_W-1:0] e0,
  output logic [MW-1:0]    m0,
  output logic [MW-1:0]    m1,
  output logic [AW-1:0]    align
);
  localparam logic [EXP_W-1:0] MAXA_E = EXP_W'(MAX_ALIGN);
  localparam logic [AW-1:0]    MAXA_C = AW'(MAX_ALIGN);

  fp32_t fa, fb;
  logic [MW-1:0] ma, mb;
  logic [EXP_W-1:0] e1, ediff;
  logic a_ge;

  assign fa = a;
  assign fb = b;

  // Split fields, flush denormals, order by magnitude, saturate the shift count
  always_comb begin
    special = (fa.exp == EXP_MAX) || (fb.exp == EXP_MAX);
    ma = (fa.exp == '0) ? '0 : {1'b1, fa.man, {GUARD_BITS{1'b0}}};
    mb = (fb.exp == '0) ? '0 : {1'b1, fb.man, {GUARD_BITS{1'b0}}};
    a_ge = {fa.exp, ma} >= {fb.exp, mb};
    s0 = a_ge ? fa.sign : ~fb.sign;
    s1 = a_ge ? ~fb.sign : fa.sign;
    e0 = a_ge ? fa.exp : fb.exp;
    e1 = a_ge ? fb.exp : fa.exp;
    m0 = a_ge ? ma : mb;
    m1 = a_ge ? mb : ma;
    ediff = e0 - e1;
    align = (ediff >= MAXA_E) ? MAXA_C : ediff[AW-1:0];
  end
endmodule

// File: rtl/fp_sub_seq.sv
// Iterative single-precision subtractor, Diff = A - B, truncating.
// Alignment and normalization move one bit per cycle.
module fp_sub_seq
  import fp_pkg::*;
#(
  parameter int GUARD_BITS = 2,
  parameter int MAX_ALIGN  = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Diff,
  output logic        Cout
);
  localparam int MW = 1 + MAN_W + GUARD_BITS;
  localparam int AW = $clog2(MAX_ALIGN + 1);
  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  state_t state, state_n;

  logic [31:0]      a_q, b_q;
  logic [MW-1:0]    m0, m1, mant;
  logic [EXP_W-1:0] e0, ex;
  logic             s0, esub;
  logic [AW-1:0]    cnt;

  logic             u_special, u_s0, u_s1;
  logic [EXP_W-1:0] u_e0;
  logic [MW-1:0]    u_m0, u_m1;
  logic [AW-1:0]    u_align;

  fp_unpack #(.GUARD_BITS(GUARD_BITS), .MAX_ALIGN(MAX_ALIGN)) u_unpack (
    .a(a_q), .b(b_q), .special(u_special), .s0(u_s0), .s1(u_s1),
    .e0(u_e0), .m0(u_m0), .m1(u_m1), .align(u_align)
  );

  logic [MW:0]      sum;
  logic             carry, ovf, sum_zero;
  logic [EXP_W-1:0] e0_inc, ex_dec;
  logic [MW-1:0]    shl;
  logic             uflow;

  // Magnitude add/sub and single-step normalize; op0 >= op1 so sub never borrows
  always_comb begin
    sum      = esub ? ({1'b0, m0} - {1'b0, m1}) : ({1'b0, m0} + {1'b0, m1});
    sum_zero = (sum == '0);
    carry    = sum[MW];
    e0_inc   = e0 + 8'd1;
    ovf      = carry && (e0_inc == EXP_MAX);
    shl      = mant << 1;
    ex_dec   = ex - 8'd1;
    uflow    = (ex_dec == '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = UNPACK;
      UNPACK: if (u_special)            state_n = DONE;
              else if (u_align == '0)   state_n = ADD;
              else                      state_n = ALIGN;
      ALIGN:  if (cnt == CNT_ONE) state_n = ADD;
      ADD:    if (sum_zero || carry || sum[MW-1]) state_n = DONE;
              else                                state_n = NORM;
      NORM:   if (uflow || shl[MW-1]) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath; Diff/Cout are written on the transition into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0;
      m0 <= '0; m1 <= '0; mant <= '0;
      e0 <= '0; ex <= '0; s0 <= 1'b0; esub <= 1'b0; cnt <= '0;
      Diff <= '0; Cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q <= A;
          b_q <= B;
        end
        UNPACK: begin
          m0 <= u_m0; m1 <= u_m1; e0 <= u_e0; s0 <= u_s0;
          esub <= u_s0 ^ u_s1;
          cnt <= u_align;
          if (u_special) begin
            Diff <= QNAN;
            Cout <= 1'b0;
          end
        end
        ALIGN: begin
          m1  <= m1 >> 1;
          cnt <= cnt - CNT_ONE;
        end
        ADD: begin
          if (sum_zero) begin
            Diff <= '0;
            Cout <= 1'b0;
          end else if (ovf) begin
            Diff <= {s0, EXP_MAX, {MAN_W{1'b0}}};
            Cout <= 1'b1;
          end else if (carry) begin
            Diff <= {s0, e0_inc, sum[MW-1:GUARD_BITS+1]};
            Cout <= 1'b0;
          end else if (sum[MW-1]) begin
            Diff <= {s0, e0, sum[MW-2:GUARD_BITS]};
            Cout <= 1'b0;
          end else begin
            mant <= sum[MW-1:0];
            ex   <= e0;
          end
        end
        NORM: begin
          if (uflow) begin
            Diff <= {s0, 31'd0};
            Cout <= 1'b0;
          end else if (shl[MW-1]) begin
            Diff <= {s0, ex_dec, shl[MW-2:GUARD_BITS]};
            Cout <= 1'b0;
          end else begin
            mant <= shl;
            ex   <= ex_dec;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed bench for fp_sub_seq: results, latency, handshake, hold, reset abort.
module tb_fp_sub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, Cout;
  logic [31:0] Diff;

  int n_chk = 0, n_pass = 0;
  logic [31:0] last_d = '0;
  logic        last_c = 1'b0;

  fp_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Diff(Diff), .Cout(Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Issue one op from an IDLE negedge; leaves at the IDLE negedge after done.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_c, input int exp_lat);
    int cyc;
    int bad_busy = 0;
    int bad_hold = 0;
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (!busy) bad_busy++;
      if (Diff !== last_d || Cout !== last_c) bad_hold++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":lat"}, cyc, exp_lat);
    chk({tag, ":diff"}, Diff, exp_d);
    chk({tag, ":cout"}, 32'(Cout), 32'(exp_c));
    chk({tag, ":busy"}, bad_busy, 0);
    chk({tag, ":hold"}, bad_hold, 0);
    last_d = exp_d; last_c = exp_c;
    @(negedge clk);
    chk({tag, ":pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [31:0] got;

    #12;
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:diff", Diff, 32'h0);
    chk("rst:cout", 32'(Cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // back-to-back sequence: each op starts the cycle after the previous done
    run_op("3-1",      32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4);
    run_op("x-x",      32'hC0933333, 32'hC0933333, 32'h00000000, 1'b0, 3);
    run_op("1+1",      32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 3);
    run_op("1-3",      32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 4);
    run_op("2^24-1",   32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 1'b0, 28);
    run_op("trunc",    32'h3F800000, 32'h33C00000, 32'h3F7FFFFE, 1'b0, 28);
    run_op("norm2",    32'h3FC00000, 32'h3FA00000, 32'h3E800000, 1'b0, 5);
    run_op("al26",     32'h3F800000, 32'h32800000, 32'h3F800000, 1'b0, 29);
    run_op("alcap",    32'h3F800000, 32'h30000000, 32'h3F800000, 1'b0, 29);
    run_op("denorm",   32'h3F800000, 32'h00000005, 32'h3F800000, 1'b0, 29);
    run_op("zero",     32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 3);
    run_op("uflow",    32'h00800000, 32'h00800001, 32'h80000000, 1'b0, 4);
    run_op("ovf",      32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 3);
    run_op("nan",      32'h7F800000, 32'h12345678, 32'h7FC00000, 1'b0, 2);

    // start while busy is ignored: one done carrying the first result
    A = 32'h4B800000; B = 32'h3F800000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    A = 32'h40400000; B = 32'h3F800000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; got = '0;
    repeat (60) begin
      if (done) begin ndone++; got = Diff; end
      @(negedge clk);
    end
    chk("ign:ndone", ndone, 1);
    chk("ign:diff", got, 32'h4B7FFFFF);

    // reset mid-ALIGN: outputs clear at once, no done follows
    A = 32'h4B800000; B = 32'h3F800000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst:busy", 32'(busy), 32'd0);
    chk("arst:done", 32'(done), 32'd0);
    chk("arst:diff", Diff, 32'h0);
    chk("arst:cout", 32'(Cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("arst:nodone", ndone, 0);
    chk("arst:idle", 32'(busy), 32'd0);
    last_d = '0; last_c = 1'b0;
    run_op("post", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
